risc_v_mem_arbiter: RTL and testbench

Arbiter and sequencer sharing a single unified memory port between the `risc_v` core's instruction-fetch stage and its load/store unit. It sits between the core and the memory model. It serialises one transaction at a time through a three-state FSM, holds the memory request stable until the memory acknowledges, and returns read data with a one-cycle acknowledge pulse to the winning requester. Data accesses have priority over fetches, with an optional anti-starvation guard.

---
 rtl/risc_v_pkg.sv | 18 +
 rtl/risc_v_starve_cnt.sv | 30 +++
 rtl/risc_v_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_risc_v_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_pkg.sv
// Shared types and constants for the risc_v memory arbiter: FSM state
// encodings, grant-owner codes and default widths.
package risc_v_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/risc_v_starve_cnt.sv
// Saturating counter of data grants issued while a fetch waits; limit_hit
// tells the arbiter to hand the next grant to the fetch side.
module risc_v_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int            CW  = $clog2(LIMIT + 2);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_hit = (cnt == LIM);

endmodule

// File: rtl/risc_v_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time. Optional anti-starvation: RISC_V_ARB_STARVE_GUARD_EN.
//
// Handshake: a requester raises *_req with stable fields and holds it until
// its *_ack pulse (one cycle); the memory side sees m_req held with stable
// fields until it returns m_ack, which may be asserted in m_req's first cycle.
module risc_v_mem_arbiter
    import risc_v_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_ack,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack,
    output logic                o_owner,
    output logic                o_busy,
    output logic [1:0]          dbg_state
);

    arb_state_t state_q, state_d;
    logic       if_elig, ls_elig;
    logic       pick_ls, pick_if;
    logic       grant_ls, grant_if;
    logic       starve_hit;

    // A requester whose ack is high right now is dropping its old request.
    assign if_elig = if_req & ~if_ack;
    assign ls_elig = ls_req & ~ls_ack;

`ifdef RISC_V_ARB_STARVE_GUARD_EN
    risc_v_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .inc       (grant_ls & if_req),
        .clr       (grant_if),
        .limit_hit (starve_hit)
    );
`else
    // Strict data priority; the limit only matters in the guarded build.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pick_ls  = ls_elig & ~(if_elig & starve_hit);
        pick_if  = if_elig & ~pick_ls;
        grant_ls = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            IDLE: begin
                grant_ls = pick_ls;
                grant_if = pick_if;
                if (pick_ls) begin
                    state_d = DATA;
                end else if (pick_if) begin
                    state_d = FETCH;
                end
            end
            FETCH, DATA: begin
                if (m_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
            if_ack   <= 1'b0;
            ls_ack   <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
            o_owner  <= OWN_IF;
        end else begin
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
            if (grant_ls) begin
                m_req   <= 1'b1;
                m_we    <= ls_we;
                m_addr  <= ls_addr;
                m_wdata <= ls_wdata;
                m_wstrb <= ls_wstrb;
                o_owner <= OWN_LS;
            end else if (grant_if) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= '0;
                m_wstrb <= '1;
                o_owner <= OWN_IF;
            end else if (m_ack && (state_q == FETCH)) begin
                m_req    <= 1'b0;
                if_ack   <= 1'b1;
                if_rdata <= m_rdata;
            end else if (m_ack && (state_q == DATA)) begin
                m_req  <= 1'b0;
                ls_ack <= 1'b1;
                if (!m_we) begin
                    ls_rdata <= m_rdata;
                end
            end
        end
    end

    assign o_busy    = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_risc_v_mem_arbiter.sv
// Randomised scoreboard bench for risc_v_mem_arbiter with directed scenarios
// for fetch, priority, store, reset abort and late memory acks.
module tb_risc_v_mem_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } ack_t;

    logic        i_clk, i_rst;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_ack;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_wstrb, m_wstrb;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        o_owner, o_busy;
    logic [1:0]  dbg_state;

    risc_v_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wstrb  (ls_wstrb),
        .ls_rdata  (ls_rdata),
        .ls_ack    (ls_ack),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ack     (m_ack),
        .o_owner   (o_owner),
        .o_busy    (o_busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard bookkeeping ----------------
    int   n_checks = 0;
    int   n_fail   = 0;
    req_t exp_req_q[$];
    ack_t exp_ack_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    bit          mem_manual = 1'b0;
    bit          mem_force_ack = 1'b0;
    int          mem_fix_lat = -1;
    bit          mem_fix_data_en = 1'b0;
    logic [31:0] mem_fix_data = '0;
    bit          mem_active = 1'b0;
    int          mem_cnt = 0;

    always @(negedge i_clk) begin
        if (mem_manual) begin
            mem_active = 1'b0;
            m_ack      = mem_force_ack;
            m_rdata    = $urandom;
        end else if (m_req) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_cnt    = (mem_fix_lat >= 0) ? mem_fix_lat : $urandom_range(0, 3);
            end else if (mem_cnt > 0) begin
                mem_cnt--;
            end
            m_ack   = (mem_cnt == 0);
            m_rdata = mem_fix_data_en ? mem_fix_data : $urandom;
        end else begin
            mem_active = 1'b0;
            m_ack      = 1'b0;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    logic        mdl_busy, mdl_owner, mdl_load, mdl_if_ack, mdl_ls_ack;
    logic [31:0] mdl_ls_rd;
    int          mdl_starve;

    always @(posedge i_clk) begin
        bit cur_if, cur_ls, if_el, ls_el, take_ls;
        if (!i_rst) begin
            mdl_busy   = 1'b0;
            mdl_owner  = 1'b0;
            mdl_load   = 1'b0;
            mdl_if_ack = 1'b0;
            mdl_ls_ack = 1'b0;
            mdl_ls_rd  = '0;
            mdl_starve = 0;
            exp_req_q.delete();
            exp_ack_q.delete();
        end else begin
            cur_if     = mdl_if_ack;
            cur_ls     = mdl_ls_ack;
            mdl_if_ack = 1'b0;
            mdl_ls_ack = 1'b0;
            if (!mdl_busy) begin
                if_el   = if_req && !cur_if;
                ls_el   = ls_req && !cur_ls;
                take_ls = ls_el;
`ifdef RISC_V_ARB_STARVE_GUARD_EN
                if (if_el && (mdl_starve >= STARVE_LIMIT)) take_ls = 1'b0;
`endif
                if (take_ls) begin
                    exp_req_q.push_back('{owner: 1'b1, we: ls_we, addr: ls_addr,
                                          wdata: ls_wdata, strb: ls_wstrb});
                    mdl_busy  = 1'b1;
                    mdl_owner = 1'b1;
                    mdl_load  = !ls_we;
                    if (if_req && (mdl_starve < STARVE_LIMIT)) mdl_starve++;
                end else if (if_el) begin
                    exp_req_q.push_back('{owner: 1'b0, we: 1'b0, addr: if_addr,
                                          wdata: 32'h0, strb: 4'hF});
                    mdl_busy   = 1'b1;
                    mdl_owner  = 1'b0;
                    mdl_starve = 0;
                end
            end else if (m_ack) begin
                mdl_busy = 1'b0;
                if (mdl_owner) begin
                    mdl_ls_ack = 1'b1;
                    if (mdl_load) mdl_ls_rd = m_rdata;
                    exp_ack_q.push_back('{owner: 1'b1, data: mdl_ls_rd});
                end else begin
                    mdl_if_ack = 1'b1;
                    exp_ack_q.push_back('{owner: 1'b0, data: m_rdata});
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_m_req = 1'b0;

    always @(negedge i_clk) begin
        req_t r;
        ack_t a;
        if (i_rst === 1'b1) begin
            check("o_busy", o_busy, mdl_busy);
            check("if_ack_timing", if_ack, mdl_if_ack);
            check("ls_ack_timing", ls_ack, mdl_ls_ack);
            if (m_req && !prev_m_req) begin
                check("grant_expected", exp_req_q.size() > 0, 1);
                if (exp_req_q.size() > 0) begin
                    r = exp_req_q.pop_front();
                    check("m_addr", m_addr, r.addr);
                    check("m_we", m_we, r.we);
                    check("m_wstrb", m_wstrb, r.strb);
                    check("o_owner", o_owner, r.owner);
                    if (r.we) check("m_wdata", m_wdata, r.wdata);
                end
            end
            check("dual_ack", if_ack && ls_ack, 0);
            if (if_ack || ls_ack) begin
                check("ack_expected", exp_ack_q.size() > 0, 1);
                if (exp_ack_q.size() > 0) begin
                    a = exp_ack_q.pop_front();
                    check("ack_owner", ls_ack, a.owner);
                    check(ls_ack ? "ls_rdata" : "if_rdata", ls_ack ? ls_rdata : if_rdata, a.data);
                end
            end
        end
        prev_m_req = m_req;
    end

    // ---------------- driver tasks ----------------
    task automatic if_txn(input logic [31:0] a, input bit keep);
        bit got = 1'b0;
        if_req  = 1'b1;
        if_addr = a;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (if_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("if_ack_timeout", if_ack, 1'b1);
        if (!keep) if_req = 1'b0;
    endtask

    task automatic ls_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input bit keep);
        bit got = 1'b0;
        ls_req   = 1'b1;
        ls_we    = we;
        ls_addr  = a;
        ls_wdata = wd;
        ls_wstrb = st;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (ls_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ls_ack_timeout", ls_ack, 1'b1);
        if (!keep) ls_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rst    = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = '0;
        ls_wdata = '0;
        ls_wstrb = '0;
        repeat (3) @(negedge i_clk);
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wstrb", m_wstrb, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_ls_ack", ls_ack, 0);
        check("rst_o_busy", o_busy, 0);
        check("rst_o_owner", o_owner, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        check("rst_state", dbg_state, 0);
        #2 i_rst = 1'b1;
        @(negedge i_clk);

        // Fetch with zero-wait memory.
        mem_fix_lat     = 0;
        mem_fix_data_en = 1'b1;
        mem_fix_data    = 32'h0050_0093;
        if_txn(32'h40, 1'b0);
        check("t1_if_rdata", if_rdata, 32'h0050_0093);
        repeat (2) @(negedge i_clk);

        // Simultaneous fetch and load: data first, 3 wait cycles each.
        mem_fix_lat     = 3;
        mem_fix_data_en = 1'b0;
        fork
            if_txn(32'h80, 1'b0);
            ls_txn(1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
        join
        repeat (2) @(negedge i_clk);

        // Store: ls_rdata must keep the previous load value.
        mem_fix_lat = 1;
        ls_txn(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        repeat (2) @(negedge i_clk);

        // Reset while DATA waits for memory, then a stray late ack.
        mem_manual    = 1'b1;
        mem_force_ack = 1'b0;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h300;
        repeat (3) @(negedge i_clk);
        check("t4_m_req_before", m_req, 1);
        #2 i_rst = 1'b0;
        #1;
        check("t4_m_req_async", m_req, 0);
        check("t4_busy_async", o_busy, 0);
        check("t4_state_async", dbg_state, 0);
        check("t4_ls_ack_async", ls_ack, 0);
        ls_req = 1'b0;
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b1;
        @(negedge i_clk);
        #1 mem_force_ack = 1'b1;
        @(negedge i_clk);
        #1 mem_force_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        check("t4_m_req_after", m_req, 0);
        check("t4_ack_q_empty", exp_ack_q.size(), 0);
        mem_manual  = 1'b0;
        mem_fix_lat = -1;
        @(negedge i_clk);

        // Random mixed traffic, including requests re-presented in the ack cycle.
        fork
            begin
                bit keep;
                for (int n = 0; n < 40; n++) begin
                    keep = (n != 39) && ($urandom_range(0, 3) == 0);
                    if_txn({$urandom_range(0, 32'hFFFF), 2'b00}, keep);
                    if (!keep) repeat ($urandom_range(0, 3)) @(negedge i_clk);
                end
            end
            begin
                bit keep;
                for (int n = 0; n < 40; n++) begin
                    keep = (n != 39) && ($urandom_range(0, 2) == 0);
                    ls_txn(1'($urandom_range(0, 1)), {$urandom_range(0, 32'hFFFF), 2'b00},
                           $urandom, 4'($urandom_range(0, 15)), keep);
                    if (!keep) repeat ($urandom_range(0, 2)) @(negedge i_clk);
                end
            end
        join
        repeat (5) @(negedge i_clk);
        check("req_q_drained", exp_req_q.size(), 0);
        check("ack_q_drained", exp_ack_q.size(), 0);
        check("final_idle", o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
